// File: rtl/datapath_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_sequencer_if
//  Purpose  : Bundles the program-load, run-control and datapath-control
//             signals of the datapath micro-sequencer. The master side is
//             the software/datapath environment and the slave side is the
//             sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface datapath_sequencer_if #(
  parameter int DEPTH = 16,
  parameter int PC_W  = $clog2(DEPTH)
);
  // Program load and run control
  logic            prog_wr_en;
  logic [PC_W-1:0] prog_wr_addr;
  logic [10:0]     prog_wr_data;
  logic [PC_W:0]   prog_len;
  logic            start;
  logic            abort;
  logic            overflow;

  // Status and datapath control
  logic            busy;
  logic            done;
  logic            ovf_stop;
  logic [PC_W-1:0] pc;
  logic [1:0]      reg_read_addr1;
  logic [1:0]      reg_read_addr2;
  logic [1:0]      reg_write_addr;
  logic            reg_write_enable;
  logic [2:0]      alu_control;

  modport master (
    output prog_wr_en, prog_wr_addr, prog_wr_data, prog_len, start, abort, overflow,
    input  busy, done, ovf_stop, pc, reg_read_addr1, reg_read_addr2,
           reg_write_addr, reg_write_enable, alu_control
  );

  modport slave (
    input  prog_wr_en, prog_wr_addr, prog_wr_data, prog_len, start, abort, overflow,
    output busy, done, ovf_stop, pc, reg_read_addr1, reg_read_addr2,
           reg_write_addr, reg_write_enable, alu_control
  );
endinterface
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_sequencer
//  Purpose  : Micro-sequencer that issues one micro-instruction per clock
//             from a small program memory onto the register-file/ALU
//             datapath control inputs, then pulses done.
//             Instruction word: {halt, we, alu[2:0], wa[1:0], ra1[1:0], ra2[1:0]}
//  Option   : DATAPATH_SEQ_STOP_ON_OVF_EN - when defined, an ALU overflow
//             ends the run (after its write) and sets ovf_stop.
//  Revision : 1.0 - initial release
// ============================================================================
module datapath_sequencer #(
  parameter int DEPTH = 16,
  parameter int PC_W  = $clog2(DEPTH)
) (
  input wire clk,
  input wire rst,
  datapath_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W:0] c_depth = (PC_W+1)'(DEPTH);
  localparam logic [PC_W:0] c_one   = (PC_W+1)'(1);

  state_t          r_state;
  logic [10:0]     r_mem [DEPTH];
  logic [10:0]     r_ins;        // instruction currently on the outputs (0 outside RUN)
  logic [PC_W:0]   r_len;        // effective run length, clamped to DEPTH
  logic [PC_W:0]   r_cnt;        // instructions issued so far; one wider so DEPTH fits
  logic [PC_W-1:0] r_pc;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf_stop;

  logic [PC_W-1:0] w_fetch_addr;
  logic [10:0]     w_fetch;
  logic [PC_W:0]   w_len;
  logic            w_accept;
  logic            w_ovf_hit;
  logic            w_last;

  assign w_accept     = bus.start && !bus.abort;
  assign w_len        = (bus.prog_len > c_depth) ? c_depth : bus.prog_len;
  // In RUN the counter already points at the next instruction to issue
  assign w_fetch_addr = (r_state == S_RUN) ? r_cnt[PC_W-1:0] : '0;
  assign w_fetch      = r_mem[w_fetch_addr];

`ifdef DATAPATH_SEQ_STOP_ON_OVF_EN
  assign w_ovf_hit = bus.overflow;
`else
  logic unused_overflow;
  assign unused_overflow = bus.overflow;
  assign w_ovf_hit       = 1'b0;
`endif

  // The instruction on the outputs is the final one when the count is reached,
  // it carries halt, or the datapath flagged overflow on it
  assign w_last = (r_cnt == r_len) || r_ins[10] || w_ovf_hit;

  // Program memory: cleared to NOPs by reset, writable only while not running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.prog_wr_en && (r_state != S_RUN)) begin
      r_mem[bus.prog_wr_addr] <= bus.prog_wr_data;
    end
  end

  // Control FSM: sequences the run and registers every datapath-facing output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ins      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_pc       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf_stop <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len      <= w_len;
            r_ovf_stop <= 1'b0;
            if (w_len == '0) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_ins   <= w_fetch;
              r_pc    <= '0;
              r_busy  <= 1'b1;
              r_cnt   <= c_one;
            end
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_ins   <= '0;
            r_pc    <= '0;
            r_busy  <= 1'b0;
          end else if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ins   <= '0;
            r_pc    <= '0;
            r_busy  <= 1'b0;
            if (w_ovf_hit) begin
              r_ovf_stop <= 1'b1;
            end
          end else begin
            r_ins <= w_fetch;
            r_pc  <= r_cnt[PC_W-1:0];
            r_cnt <= r_cnt + c_one;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.ovf_stop         = r_ovf_stop;
  assign bus.pc               = r_pc;
  assign bus.reg_write_enable = r_ins[9];
  assign bus.alu_control      = r_ins[8:6];
  assign bus.reg_write_addr   = r_ins[5:4];
  assign bus.reg_read_addr1   = r_ins[3:2];
  assign bus.reg_read_addr2   = r_ins[1:0];

endmodule
`default_nettype wire

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Micro-sequencer that drives the register-file/ALU datapath control inputs from a small on-chip program memory.
- Software-side logic writes up to DEPTH micro-instructions, then pulses Start; the block issues one instruction per clock and signals Done.
- Sits directly in front of the datapath. Its register-address, write-enable and ALU-control outputs connect 1:1 to the datapath inputs.

Parameters:
- DEPTH, 16, number of program-memory entries; power of two, at least 2.
- PC_W, $clog2(DEPTH), program-counter and write-address width.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- ProgWrEn  input  1  program-memory write strobe.
- ProgWrAddr  input  PC_W  program-memory write address.
- ProgWrData  input  11  instruction {Halt[10], We[9], Alu[8:6], Wa[5:4], Ra1[3:2], Ra2[1:0]}.
- ProgLen  input  PC_W+1  number of instructions to run; sampled on accepted Start.
- Start  input  1  begin execution (level sampled in IDLE).
- Abort  input  1  terminate run without Done.
- Overflow  input  1  ALU overflow from datapath (used only with the optional feature).
- Busy  output  1  high while instructions are being issued.
- Done  output  1  one-cycle completion pulse.
- OvfStop  output  1  run ended by overflow; held until next accepted Start.
- PC  output  PC_W  index of instruction currently on the control outputs.
- RegReadAddr1  output  2  to datapath.
- RegReadAddr2  output  2  to datapath.
- RegWriteAddr  output  2  to datapath.
- RegWriteEnable  output  1  to datapath.
- ALUControl  output  3  to datapath.

Behaviour:
- **Reset.** Async Rst forces the following, all held while Rst is high:
  - state IDLE;
  - all outputs 0;
  - all memory entries cleared to 0 (a NOP, We=0).
- **States.** IDLE, RUN, DONE.
- **Program writes.**
  - Writes occur in IDLE or DONE only.
  - ProgWrEn in RUN is ignored; the memory is unchanged.
- **IDLE.**
  - Start=1 and Abort=0 latches len = min(ProgLen, DEPTH) and an internal counter of 0.
  - If len=0: go to DONE directly, with no instruction issued.
  - Otherwise: go to RUN.
- **Issue timing.** Start is sampled at edge t.
  - Instruction k appears on the registered outputs during cycle t+1+k.
  - PC=k during that cycle.
  - Busy=1 during cycles t+1 .. t+len.
  - RegWriteEnable equals the instruction's We bit only while in RUN.
- **Last instruction.** The run ends after issuing the instruction with k=len-1 or with Halt=1, whichever comes first.
  - The halt instruction itself is issued and executed.
  - The next cycle is DONE.
- **DONE.**
  - Done=1 for exactly one cycle.
  - Busy=0, RegWriteEnable=0; other control outputs are zeroed.
  - The state returns to IDLE.
  - A Start arriving during DONE is ignored.
- **Start while Busy.** Ignored.
- **Abort in RUN.**
  - At the next edge, control outputs go to 0, Busy=0, state IDLE, and no Done is produced.
  - The instruction on the outputs during the Abort cycle is still written by the datapath.
- **Abort with Start in IDLE.** Abort wins and the run does not start.
- **Counters.** The internal counter is PC_W+1 bits, so len=DEPTH is reached without wrap. PC never exceeds DEPTH-1.
- **Reset mid-run.** Outputs drop to 0 immediately (asynchronously). No Done.

Optional Feature:
- Macro: DATAPATH_SEQ_STOP_ON_OVF_EN.
- **Defined.**
  - Overflow is sampled on each RUN edge. Overflow=1 ends the run as if the current instruction had Halt=1.
  - The overflowing instruction's write still occurs.
  - DONE follows with Done=1, and OvfStop is set to 1.
  - OvfStop is cleared on the next accepted Start.
- **Undefined.**
  - Overflow is ignored and OvfStop is tied to 0.
  - The port list is unchanged.

Test Plan:
1. **Reset values.** Assert Rst mid-cycle → all outputs 0 immediately; after release, memory reads return NOP (Start with ProgLen=2 issues We=0, Alu=0 twice, then Done).
2. **Normal run.**
   - Stimulus: load 3 instructions, Start with ProgLen=3 at edge t.
   - Required:
     - outputs show instr0/1/2 in cycles t+1..t+3;
     - PC=0,1,2 in those cycles;
     - Busy high for exactly 3 cycles;
     - Done single pulse in cycle t+4.
3. **Halt bit.**
   - Stimulus: ProgLen=8, instr2 has Halt=1.
   - Required: exactly 3 instructions issued, Done at t+4, instr3 never appears.
4. **Empty and over-length programs.**
   - ProgLen=0 → Done at t+1, Busy never high.
   - ProgLen=31 with DEPTH=16 → 16 instructions issued (PC 0..15), Done at t+17.
5. **Abort and ignored inputs.**
   - Abort during PC=1 → cycle after: Busy=0, RegWriteEnable=0, no Done.
   - ProgWrEn during RUN → memory unchanged, verified by rerun.
   - Start+Abort together in IDLE → no run.
6. **Overflow stop (macro defined).**
   - Stimulus: Overflow=1 while PC=1 of a 4-instruction run.
   - Required: Done at the next cycle and OvfStop=1; OvfStop clears on the next Start.
   - Same stimulus with the macro undefined → all 4 instructions issued, OvfStop=0.
